// File: rtl/sample_serializer_if.sv
// Word-in / byte-out bundle for the sample serializer.
// Signal names follow the direction as seen from the serializer itself.
interface sample_serializer_if;
  logic [31:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  grp_en_i;
  logic [7:0]  byte_o;
  logic        byte_valid_o;
  logic        byte_ready_i;
  logic        busy_o;

  // Serializer side
  modport slave (
    input  data_i,
    input  valid_i,
    output ready_o,
    input  grp_en_i,
    output byte_o,
    output byte_valid_o,
    input  byte_ready_i,
    output busy_o
  );

  // Producer / transmitter side
  modport master (
    output data_i,
    output valid_i,
    input  ready_o,
    output grp_en_i,
    input  byte_o,
    input  byte_valid_o,
    output byte_ready_i,
    input  busy_o
  );
endinterface : sample_serializer_if

// File: rtl/sample_serializer.sv
// Sample serializer: accepts one 32-bit sample word, then emits the bytes of
// the enabled channel groups (ascending group order) to a UART transmitter.
// All outputs are registered; ready_o has no combinational input path.
module sample_serializer (
  input  logic               clk_i,
  input  logic               rst_in,
  sample_serializer_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Byte of group idx from a captured word.
  function automatic logic [7:0] sel_byte(input logic [31:0] word,
                                          input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Lowest set bit of a group mask as {found, index}.
  function automatic logic [2:0] lowest_grp(input logic [3:0] mask);
    logic [2:0] r;
    if (mask[0]) begin
      r = 3'b100;
    end else if (mask[1]) begin
      r = 3'b101;
    end else if (mask[2]) begin
      r = 3'b110;
    end else if (mask[3]) begin
      r = 3'b111;
    end else begin
      r = 3'b000;
    end
    return r;
  endfunction

  // Next enabled group strictly above idx as {found, index}; skipping
  // disabled groups this way costs no extra cycles.
  function automatic logic [2:0] next_grp(input logic [3:0] mask,
                                          input logic [1:0] idx);
    logic [3:0] above;
    case (idx)
      2'd0:    above = mask & 4'b1110;
      2'd1:    above = mask & 4'b1100;
      2'd2:    above = mask & 4'b1000;
      2'd3:    above = 4'b0000;
      default: above = 4'b0000;
    endcase
    return lowest_grp(above);
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [3:0]  snap_q, snap_d;
  logic [7:0]  byte_q, byte_d;
  logic        byte_valid_q, byte_valid_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;

  logic [2:0]  first_s;
  logic [2:0]  next_s;
  logic        word_xfer_s;
  logic        byte_xfer_s;

  // The live mask only matters at the word transfer; afterwards only the
  // snapshot is consulted, so mid-word mask changes cannot disturb a word.
  assign first_s     = lowest_grp(bus.grp_en_i);
  assign next_s      = next_grp(snap_q, idx_q);
  assign word_xfer_s = bus.valid_i & ready_q;
  assign byte_xfer_s = byte_valid_q & bus.byte_ready_i;

  // Next-state and next-output logic of the IDLE/SHIFT machine.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    word_d       = word_q;
    snap_d       = snap_q;
    byte_d       = byte_q;
    byte_valid_d = byte_valid_q;
    busy_d       = busy_q;
    ready_d      = ready_q;

    case (state_q)
      ST_IDLE: begin
        ready_d      = 1'b1;
        byte_valid_d = 1'b0;
        busy_d       = 1'b0;
        if (word_xfer_s) begin
          word_d = bus.data_i;
          snap_d = bus.grp_en_i;
          if (first_s[2]) begin
            state_d      = ST_SHIFT;
            idx_d        = first_s[1:0];
            byte_d       = sel_byte(bus.data_i, first_s[1:0]);
            byte_valid_d = 1'b1;
            busy_d       = 1'b1;
            ready_d      = 1'b0;
          end else begin
            // Empty mask: the word is consumed and silently dropped.
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        ready_d = 1'b0;
        if (byte_xfer_s) begin
          if (next_s[2]) begin
            state_d      = ST_SHIFT;
            idx_d        = next_s[1:0];
            byte_d       = sel_byte(word_q, next_s[1:0]);
            byte_valid_d = 1'b1;
            busy_d       = 1'b1;
          end else begin
            state_d      = ST_IDLE;
            byte_d       = 8'h00;
            byte_valid_d = 1'b0;
            busy_d       = 1'b0;
            ready_d      = 1'b1;
          end
        end else begin
          // Backpressure: hold the current byte untouched.
          state_d      = ST_SHIFT;
          byte_valid_d = 1'b1;
          busy_d       = 1'b1;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        idx_d        = 2'd0;
        byte_d       = 8'h00;
        byte_valid_d = 1'b0;
        busy_d       = 1'b0;
        ready_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything, discarding any
  // partially serialized word.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= ST_IDLE;
      idx_q        <= 2'd0;
      word_q       <= 32'h0000_0000;
      snap_q       <= 4'b0000;
      byte_q       <= 8'h00;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      snap_q       <= snap_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
    end
  end

  assign bus.ready_o      = ready_q;
  assign bus.byte_o       = byte_q;
  assign bus.byte_valid_o = byte_valid_q;
  assign bus.busy_o       = busy_q;

endmodule : sample_serializer

// File: tb/tb_sample_serializer.sv
// Directed + random bench for sample_serializer with a byte scoreboard.
module tb_sample_serializer;

  logic clk_i;
  logic rst_in;

  sample_serializer_if bus ();

  sample_serializer dut (
    .clk_i  (clk_i),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int total;
  int bad;
  int byte_cnt;
  int exp_total;
  logic [7:0] exp_q [$];
  logic [7:0] exp_b;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard: push bytes of each accepted word, pop on each byte transfer.
  always @(negedge clk_i) begin
    if (rst_in && bus.valid_i && bus.ready_o) begin
      for (int g = 0; g < 4; g++) begin
        if (bus.grp_en_i[g]) exp_q.push_back(bus.data_i[8*g +: 8]);
      end
    end
    if (rst_in && bus.byte_valid_o && bus.byte_ready_i) begin
      byte_cnt++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL byte_unexpected observed=%h expected=none", bus.byte_o);
      end
      if (exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        chk("byte_stream", {24'h0, bus.byte_o}, {24'h0, exp_b});
      end
    end
  end

  // Present a word and hold it until accepted (bounded).
  task automatic send_word(input logic [31:0] d, input logic [3:0] m, input bit rnd);
    logic acc;
    int n;
    bus.data_i   = d;
    bus.grp_en_i = m;
    bus.valid_i  = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk_i);
      acc = bus.ready_o;
      @(posedge clk_i);
      #1;
      if (rnd) bus.byte_ready_i = 1'($urandom_range(0, 1));
      n++;
    end
    bus.valid_i = 1'b0;
    if (acc) exp_total += $countones(m);
    chk("word_accepted", {31'h0, acc}, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.byte_ready_i = 1'b1;
    while (bus.busy_o && n < 100) begin
      step();
      n++;
    end
    chk("drain_idle", {31'h0, bus.busy_o}, 32'd0);
  endtask

  int base;

  initial begin
    total = 0; bad = 0; byte_cnt = 0; exp_total = 0;
    rst_in = 1'b0;
    bus.data_i = 32'h0; bus.valid_i = 1'b0; bus.grp_en_i = 4'h0; bus.byte_ready_i = 1'b0;

    // Reset state
    step(); step();
    chk("rst_ready", {31'h0, bus.ready_o}, 32'd0);
    chk("rst_bvalid", {31'h0, bus.byte_valid_o}, 32'd0);
    chk("rst_busy", {31'h0, bus.busy_o}, 32'd0);
    chk("rst_byte", {24'h0, bus.byte_o}, 32'h0);
    rst_in = 1'b1;
    #1;
    chk("ready_before_edge", {31'h0, bus.ready_o}, 32'd0);
    step();
    chk("ready_after_release", {31'h0, bus.ready_o}, 32'd1);

    // Full mask, no backpressure: AA BB CC DD back to back, ready on 5th
    bus.byte_ready_i = 1'b1;
    base = byte_cnt;
    send_word(32'hDDCCBBAA, 4'hF, 1'b0);
    chk("f_busy", {31'h0, bus.busy_o}, 32'd1);
    chk("f_ready_low", {31'h0, bus.ready_o}, 32'd0);
    chk("f_b0", {23'h0, bus.byte_valid_o, bus.byte_o}, {23'h0, 1'b1, 8'hAA});
    step();
    chk("f_b1", {23'h0, bus.byte_valid_o, bus.byte_o}, {23'h0, 1'b1, 8'hBB});
    step();
    chk("f_b2", {23'h0, bus.byte_valid_o, bus.byte_o}, {23'h0, 1'b1, 8'hCC});
    step();
    chk("f_b3", {23'h0, bus.byte_valid_o, bus.byte_o}, {23'h0, 1'b1, 8'hDD});
    step();
    chk("f_ready_back", {31'h0, bus.ready_o}, 32'd1);
    chk("f_bvalid_off", {31'h0, bus.byte_valid_o}, 32'd0);
    chk("f_busy_off", {31'h0, bus.busy_o}, 32'd0);
    chk("f_count", byte_cnt - base, 32'd4);

    // Sparse mask 1010: only 22 and 44
    base = byte_cnt;
    send_word(32'h44332211, 4'b1010, 1'b0);
    chk("s_b0", {24'h0, bus.byte_o}, 32'h22);
    step();
    chk("s_b1", {24'h0, bus.byte_o}, 32'h44);
    step();
    chk("s_idle", {31'h0, bus.ready_o}, 32'd1);
    chk("s_count", byte_cnt - base, 32'd2);

    // Backpressure on AA for 3 cycles
    base = byte_cnt;
    bus.byte_ready_i = 1'b0;
    send_word(32'hDDCCBBAA, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", {23'h0, bus.byte_valid_o, bus.byte_o}, {23'h0, 1'b1, 8'hAA});
      step();
    end
    drain();
    chk("bp_count", byte_cnt - base, 32'd4);

    // Empty mask: word dropped
    base = byte_cnt;
    send_word(32'h12345678, 4'h0, 1'b0);
    chk("z_ready", {31'h0, bus.ready_o}, 32'd1);
    chk("z_busy", {31'h0, bus.busy_o}, 32'd0);
    step();
    chk("z_bvalid", {31'h0, bus.byte_valid_o}, 32'd0);
    chk("z_count", byte_cnt - base, 32'd0);

    // Mask change mid-word does not affect the word in progress
    base = byte_cnt;
    send_word(32'hDDCCBBAA, 4'hF, 1'b0);
    step();
    bus.grp_en_i = 4'h1;
    drain();
    chk("m_count", byte_cnt - base, 32'd4);
    base = byte_cnt;
    send_word(32'h000000EE, 4'h1, 1'b0);
    chk("m_ee", {24'h0, bus.byte_o}, 32'hEE);
    drain();
    chk("m_count2", byte_cnt - base, 32'd1);

    // Reset while BB pending
    step();
    send_word(32'hDDCCBBAA, 4'hF, 1'b0);
    step();
    bus.byte_ready_i = 1'b0;
    chk("r_bb_pending", {24'h0, bus.byte_o}, 32'hBB);
    base = byte_cnt;
    #2;
    rst_in = 1'b0;
    #1;
    chk("r_bvalid_async", {31'h0, bus.byte_valid_o}, 32'd0);
    chk("r_busy_async", {31'h0, bus.busy_o}, 32'd0);
    exp_q.delete();
    step(); step();
    rst_in = 1'b1;
    bus.byte_ready_i = 1'b1;
    step();
    chk("r_ready", {31'h0, bus.ready_o}, 32'd1);
    step(); step();
    chk("r_no_residual", {31'h0, bus.byte_valid_o}, 32'd0);
    chk("r_count", byte_cnt - base, 32'd0);

    // 200 random words, random masks, random byte_ready
    base = byte_cnt;
    exp_total = 0;
    for (int w = 0; w < 200; w++) begin
      send_word($urandom, 4'($urandom_range(0, 15)), 1'b1);
      repeat ($urandom_range(0, 2)) begin
        step();
        bus.byte_ready_i = 1'($urandom_range(0, 1));
      end
    end
    drain();
    step();
    chk("rnd_count", byte_cnt - base, exp_total);
    chk("rnd_queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sample_serializer
